branch_target_buffer: RTL and testbench
=======================================

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL have exactly one clock and one reset: the reset is synchronous and active-high.
REQ-002 Port: clk_i  input  1  rising-edge clock for all state.
REQ-003 Port: rst_i  input  1  synchronous active-high reset.
REQ-004 Port: pc_IF  input  32  fetch-stage PC used for lookup.
REQ-005 Port: update  input  1  write enable; install the entry for pc_EX on the next rising edge.
REQ-006 Port: pc_EX  input  32  execute-stage branch PC being installed.
REQ-007 Port: aludata_EX  input  32  resolved branch target to store.
REQ-008 Port: tag  output  20  stored tag of the entry indexed by pc_IF.
REQ-009 Port: predictedPC  output  32  stored target of the entry indexed by pc_IF.
REQ-010 Parameter: none; geometry comes from package constants.

Function
REQ-011 SHALL be direct-mapped with 1024 entries; each entry SHALL hold valid (1b), tag (20b) and target (32b).
REQ-012 Lookup index SHALL be pc_IF[11:2]; write index SHALL be pc_EX[11:2]; pc bits [1:0] are ignored.
REQ-013 Lookup SHALL be combinational (zero latency): tag and predictedPC follow pc_IF in the same cycle.
REQ-014 Valid entry: tag = stored tag, predictedPC = stored target.
REQ-015 Invalid entry: tag SHALL be ~pc_IF[31:12], so an external compare against pc_IF[31:12] always misses; predictedPC SHALL be pc_IF + 32'd4, computed modulo 2^32.
REQ-016 On a rising edge with update=1 and rst_i=0, entry[pc_EX[11:2]] SHALL become valid, with tag = pc_EX[31:12] and target = aludata_EX.
REQ-017 A write SHALL overwrite any existing entry at that index, including an aliasing entry whose tag differs.
REQ-018 Same-cycle read and write to the same index: the outputs SHALL show the pre-edge contents, and the new contents SHALL be visible from the cycle after the edge.
REQ-019 update=0 SHALL leave all state unchanged; the value of update SHALL not affect the lookup outputs in the same cycle.
REQ-020 X or unknown values on pc_EX/aludata_EX SHALL be tolerated while update=0.

Reset
REQ-021 While rst_i=1 at a rising edge, all 1024 valid bits SHALL clear.
REQ-022 Tag and target storage SHALL not be reset.
REQ-023 Reset SHALL take priority over a simultaneous update; the write is dropped.
REQ-024 After reset, outputs SHALL obey REQ-015 for every pc_IF until entries are written.

Structure
REQ-025 Shared package btb_pkg SHALL hold BTB_ENTRIES=1024, BTB_IDX_W=10, BTB_TAG_W=20, PC_W=32 and a packed typedef btb_entry_t {valid, tag, target}.
REQ-026 SHALL be a single module with no sub-modules: the valid bits are a flop vector with reset, and tag/target is a plain array with asynchronous read.

Verification
REQ-027 Reset, then pc_IF=32'h0000_1000 -> tag=20'hFFFFE, predictedPC=32'h0000_1004.
REQ-028 update=1, pc_EX=32'h0000_2040, aludata_EX=32'h0000_3000 for one edge; then pc_IF=32'h0000_2040 -> tag=20'h00002, predictedPC=32'h0000_3000.
REQ-029 Alias: after REQ-028, write pc_EX=32'h0001_2040, aludata_EX=32'h0000_0100; pc_IF=32'h0000_2040 -> tag=20'h00012, predictedPC=32'h0000_0100.
REQ-030 Same-cycle: pc_IF=pc_EX=32'h0000_0080 with update=1 -> invalid outputs before the edge (tag=20'hFFFFF, predictedPC=32'h0000_0084), new entry after the edge.
REQ-031 rst_i=1 together with update=1 at pc_EX=32'h0000_0010 -> entry stays invalid; wrap check pc_IF=32'hFFFF_FFFC invalid -> predictedPC=32'h0000_0000.
REQ-032 Index edges: write pc_EX=32'h0000_0000 and 32'h0000_0FFC -> entries 0 and 1023 are independent, with no cross-talk.

Source files
------------

// File: rtl/btb_pkg.sv
// ---------------------------------------------------------------------------
// btb_pkg
//
// Purpose:
//   Shared geometry and entry layout for the branch target buffer.
//
//   The BTB is direct-mapped. A 32-bit PC is split as follows:
//     pc[31:12]  tag (20 bits)
//     pc[11:2]   index (10 bits, 1024 entries)
//     pc[1:0]    ignored, because instructions are word aligned
//
// Contents:
//   BTB_ENTRIES, BTB_IDX_W, BTB_TAG_W, PC_W  geometry constants
//   IDX_LSB, TAG_LSB                         bit positions of the index and tag fields
//   btb_entry_t                              packed {valid, tag, target} entry view
//   missTag()                                tag value reported for an invalid entry
// ---------------------------------------------------------------------------
package btb_pkg;

  localparam int BTB_ENTRIES = 1024;
  localparam int BTB_IDX_W   = 10;
  localparam int BTB_TAG_W   = 20;
  localparam int PC_W        = 32;

  // The index starts above the word-offset bits. The tag takes every bit
  // above the index.
  localparam int IDX_LSB = 2;
  localparam int TAG_LSB = IDX_LSB + BTB_IDX_W;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [PC_W-1:0]      target;
  } btb_entry_t;

  // An invalid entry reports the inverse of the lookup tag. An external
  // compare against pc[31:12] therefore always misses, and no separate
  // hit/valid port is needed.
  function automatic logic [BTB_TAG_W-1:0] missTag(input logic [BTB_TAG_W-1:0] pcTag);
    return ~pcTag;
  endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// ---------------------------------------------------------------------------
// branch_target_buffer
//
// Purpose:
//   A direct-mapped branch target buffer with 1024 entries. The fetch stage
//   looks it up combinationally with pc_IF. The execute stage installs
//   resolved branch targets with update/pc_EX/aludata_EX.
//
//   A miss is signalled through the returned tag. For an invalid entry the
//   buffer returns ~pc_IF[31:12] as the tag and pc_IF+4 as the prediction.
//   The fetch stage can then compare tags and use predictedPC without
//   special-casing cold entries.
//
// Ports:
//   clk_i        in   1   rising-edge clock for all state
//   rst_i        in   1   synchronous active-high reset; clears every valid bit
//   pc_IF        in  32   fetch PC used for the combinational lookup
//   update       in   1   install the entry for pc_EX at the next rising edge
//   pc_EX        in  32   execute-stage branch PC being installed
//   aludata_EX   in  32   resolved branch target to store
//   tag          out 20   stored tag (or miss tag) for the entry at pc_IF
//   predictedPC  out 32   stored target (or pc_IF+4) for the entry at pc_IF
// ---------------------------------------------------------------------------
module branch_target_buffer
  import btb_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [PC_W-1:0]      pc_IF,
  input  logic                 update,
  input  logic [PC_W-1:0]      pc_EX,
  input  logic [PC_W-1:0]      aludata_EX,
  output logic [BTB_TAG_W-1:0] tag,
  output logic [PC_W-1:0]      predictedPC
);

  // Only the valid bits carry reset. The tag and target arrays never need
  // it, because a cleared valid bit hides whatever they hold.
  logic [BTB_ENTRIES-1:0] valid_q;
  logic [BTB_ENTRIES-1:0] valid_d;
  logic [BTB_TAG_W-1:0]   tagMem_q    [BTB_ENTRIES];
  logic [PC_W-1:0]        targetMem_q [BTB_ENTRIES];

  logic [BTB_IDX_W-1:0] rdIdx;
  logic [BTB_IDX_W-1:0] wrIdx;
  logic [BTB_TAG_W-1:0] rdPcTag;
  logic [BTB_TAG_W-1:0] wrPcTag;
  btb_entry_t           rdEntry;

  // The word-offset bits of the write PC play no part in indexing or tagging.
  logic unusedPcExBits;

  assign rdIdx   = pc_IF[IDX_LSB +: BTB_IDX_W];
  assign wrIdx   = pc_EX[IDX_LSB +: BTB_IDX_W];
  assign rdPcTag = pc_IF[TAG_LSB +: BTB_TAG_W];
  assign wrPcTag = pc_EX[TAG_LSB +: BTB_TAG_W];
  assign unusedPcExBits = ^pc_EX[IDX_LSB-1:0];

  // Next-state for the valid vector.
  // An update sets only the addressed bit. Writing over an aliasing entry
  // simply leaves the bit set. Reset is handled in the register block so
  // that it always wins over a simultaneous update.
  always_comb begin
    valid_d = valid_q;
    if (update) begin
      valid_d[wrIdx] = 1'b1;
    end
  end

  // Valid-bit register with synchronous reset.
  // Reset clears all 1024 bits in one edge, and any write presented in the
  // same cycle is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag/target storage, written without reset.
  // The write is gated by !rst_i so that a write dropped by reset leaves no
  // trace in the data arrays either. While update is low, pc_EX and
  // aludata_EX are never looked at, so unknown values there are harmless.
  always_ff @(posedge clk_i) begin
    if (update && !rst_i) begin
      tagMem_q[wrIdx]    <= wrPcTag;
      targetMem_q[wrIdx] <= aludata_EX;
    end
  end

  // Asynchronous read of the indexed entry.
  // The read looks at the registered contents only. A write to the same
  // index in the same cycle therefore becomes visible after the edge, and
  // the update input never influences the current lookup.
  always_comb begin
    rdEntry        = '0;
    rdEntry.valid  = valid_q[rdIdx];
    rdEntry.tag    = tagMem_q[rdIdx];
    rdEntry.target = targetMem_q[rdIdx];
  end

  // Output selection.
  // A hit returns the stored entry. A miss returns a tag guaranteed to
  // mismatch, together with the fall-through PC (wrapping modulo 2^32).
  always_comb begin
    tag         = missTag(rdPcTag);
    predictedPC = pc_IF + 32'd4;
    if (rdEntry.valid) begin
      tag         = rdEntry.tag;
      predictedPC = rdEntry.target;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// ---------------------------------------------------------------------------
// tb_branch_target_buffer
//
// Self-checking bench for branch_target_buffer.
//
// The bench keeps its own reference model of the buffer contents. Each
// lookup pushes its PC and expected outputs onto a scoreboard queue. Each
// test task then drives the queued PCs and pops and compares the DUT
// outputs inline.
// ---------------------------------------------------------------------------
module tb_branch_target_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] pcIf;
  logic        update;
  logic [31:0] pcEx;
  logic [31:0] aluData;
  logic [19:0] tagOut;
  logic [31:0] predPc;

  int checks;
  int errors;

  typedef struct {
    logic [31:0] pc;
    logic [19:0] expTag;
    logic [31:0] expPc;
  } exp_t;

  exp_t sbQ[$];

  // Reference model of the buffer contents, maintained by the bench.
  bit          modelValid  [1024];
  logic [19:0] modelTag    [1024];
  logic [31:0] modelTarget [1024];

  branch_target_buffer dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .pc_IF       (pcIf),
    .update      (update),
    .pc_EX       (pcEx),
    .aludata_EX  (aluData),
    .tag         (tagOut),
    .predictedPC (predPc)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected lookup result for a PC, taken from the reference model.
  function automatic exp_t expOf(input logic [31:0] pc);
    exp_t e;
    int   idx;
    idx = int'(pc[11:2]);
    e.pc = pc;
    if (modelValid[idx]) begin
      e.expTag = modelTag[idx];
      e.expPc  = modelTarget[idx];
    end else begin
      e.expTag = ~pc[31:12];
      e.expPc  = pc + 32'd4;
    end
    return e;
  endfunction

  // Queue an expectation given as explicit constants.
  task automatic pushConst(input logic [31:0] pc, input logic [19:0] t, input logic [31:0] p);
    exp_t e;
    e.pc = pc;
    e.expTag = t;
    e.expPc = p;
    sbQ.push_back(e);
  endtask

  // One write cycle: drive at the falling edge, let the rising edge
  // capture it, and then mirror the write into the model.
  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] data, input logic withReset);
    @(negedge clk);
    update  = 1'b1;
    pcEx    = pc;
    aluData = data;
    rst     = withReset;
    @(posedge clk);
    #1;
    update  = 1'b0;
    rst     = 1'b0;
    pcEx    = 'x;
    aluData = 'x;
    if (withReset) begin
      for (int i = 0; i < 1024; i++) modelValid[i] = 1'b0;
    end else begin
      modelValid[int'(pc[11:2])]  = 1'b1;
      modelTag[int'(pc[11:2])]    = pc[31:12];
      modelTarget[int'(pc[11:2])] = data;
    end
  endtask

  task automatic test_reset;
    exp_t e;
    @(negedge clk);
    rst = 1'b1;
    update = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 1024; i++) modelValid[i] = 1'b0;
    pushConst(32'h0000_1000, 20'hFFFFE, 32'h0000_1004);
    for (int i = 0; i < 4; i++) sbQ.push_back(expOf($urandom()));
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      @(negedge clk);
      pcIf = e.pc;
      #1;
      checks++;
      if (tagOut !== e.expTag || predPc !== e.expPc) begin
        errors++;
        $display("[TB] FAIL reset_lookup pc=%h got tag=%h pred=%h want tag=%h pred=%h",
                 e.pc, tagOut, predPc, e.expTag, e.expPc);
      end
    end
  endtask

  task automatic test_write;
    exp_t e;
    applyStimulus(32'h0000_2040, 32'h0000_3000, 1'b0);
    pushConst(32'h0000_2040, 20'h00002, 32'h0000_3000);
    pushConst(32'h0000_2043, 20'h00002, 32'h0000_3000);
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      @(negedge clk);
      pcIf = e.pc;
      #1;
      checks++;
      if (tagOut !== e.expTag || predPc !== e.expPc) begin
        errors++;
        $display("[TB] FAIL write_hit pc=%h got tag=%h pred=%h want tag=%h pred=%h",
                 e.pc, tagOut, predPc, e.expTag, e.expPc);
      end
    end
  endtask

  task automatic test_alias;
    exp_t e;
    applyStimulus(32'h0001_2040, 32'h0000_0100, 1'b0);
    pushConst(32'h0000_2040, 20'h00012, 32'h0000_0100);
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      @(negedge clk);
      pcIf = e.pc;
      #1;
      checks++;
      if (tagOut !== e.expTag || predPc !== e.expPc) begin
        errors++;
        $display("[TB] FAIL alias_overwrite pc=%h got tag=%h pred=%h want tag=%h pred=%h",
                 e.pc, tagOut, predPc, e.expTag, e.expPc);
      end
    end
  endtask

  task automatic test_same_cycle;
    exp_t e;
    @(negedge clk);
    pcIf    = 32'h0000_0080;
    pcEx    = 32'h0000_0080;
    aluData = 32'h0000_5554;
    update  = 1'b1;
    pushConst(32'h0000_0080, 20'hFFFFF, 32'h0000_0084);
    #1;
    e = sbQ.pop_front();
    checks++;
    if (tagOut !== e.expTag || predPc !== e.expPc) begin
      errors++;
      $display("[TB] FAIL same_cycle_pre got tag=%h pred=%h want tag=%h pred=%h",
               tagOut, predPc, e.expTag, e.expPc);
    end
    @(posedge clk);
    #1;
    update = 1'b0;
    modelValid[32]  = 1'b1;
    modelTag[32]    = 20'h00000;
    modelTarget[32] = 32'h0000_5554;
    pushConst(32'h0000_0080, 20'h00000, 32'h0000_5554);
    e = sbQ.pop_front();
    checks++;
    if (tagOut !== e.expTag || predPc !== e.expPc) begin
      errors++;
      $display("[TB] FAIL same_cycle_post got tag=%h pred=%h want tag=%h pred=%h",
               tagOut, predPc, e.expTag, e.expPc);
    end
  endtask

  task automatic test_reset_priority;
    exp_t e;
    applyStimulus(32'h0000_0010, 32'h1234_5678, 1'b1);
    pushConst(32'h0000_0010, 20'hFFFFF, 32'h0000_0014);
    pushConst(32'h0000_2040, 20'hFFFFD, 32'h0000_2044);
    pushConst(32'h0000_0080, 20'hFFFFF, 32'h0000_0084);
    pushConst(32'hFFFF_FFFC, 20'h00000, 32'h0000_0000);
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      @(negedge clk);
      pcIf = e.pc;
      #1;
      checks++;
      if (tagOut !== e.expTag || predPc !== e.expPc) begin
        errors++;
        $display("[TB] FAIL reset_priority pc=%h got tag=%h pred=%h want tag=%h pred=%h",
                 e.pc, tagOut, predPc, e.expTag, e.expPc);
      end
    end
  endtask

  task automatic test_index_edges;
    exp_t e;
    applyStimulus(32'h0000_0000, 32'hAAAA_0000, 1'b0);
    pushConst(32'h0000_0000, 20'h00000, 32'hAAAA_0000);
    pushConst(32'h0000_0FFC, 20'hFFFFF, 32'h0000_1000);
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      @(negedge clk);
      pcIf = e.pc;
      #1;
      checks++;
      if (tagOut !== e.expTag || predPc !== e.expPc) begin
        errors++;
        $display("[TB] FAIL index_edge_first pc=%h got tag=%h pred=%h want tag=%h pred=%h",
                 e.pc, tagOut, predPc, e.expTag, e.expPc);
      end
    end
    applyStimulus(32'h0000_0FFC, 32'hBBBB_0FFC, 1'b0);
    pushConst(32'h0000_0000, 20'h00000, 32'hAAAA_0000);
    pushConst(32'h0000_0FFC, 20'h00000, 32'hBBBB_0FFC);
    pushConst(32'h0000_0004, 20'hFFFFF, 32'h0000_0008);
    pushConst(32'h0000_0FF8, 20'hFFFFF, 32'h0000_0FFC);
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      @(negedge clk);
      pcIf = e.pc;
      #1;
      checks++;
      if (tagOut !== e.expTag || predPc !== e.expPc) begin
        errors++;
        $display("[TB] FAIL index_edge_both pc=%h got tag=%h pred=%h want tag=%h pred=%h",
                 e.pc, tagOut, predPc, e.expTag, e.expPc);
      end
    end
  endtask

  task automatic test_update_low;
    exp_t e;
    // Several edges with update low and unknown write data must not disturb
    // any entry.
    @(negedge clk);
    update  = 1'b0;
    pcEx    = 'x;
    aluData = 'x;
    repeat (3) @(posedge clk);
    @(negedge clk);
    pcEx    = 32'h0000_0000;
    aluData = 32'hDEAD_BEEF;
    @(posedge clk);
    sbQ.push_back(expOf(32'h0000_0000));
    sbQ.push_back(expOf(32'h0000_0FFC));
    sbQ.push_back(expOf(32'h0000_0080));
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      @(negedge clk);
      pcIf = e.pc;
      #1;
      checks++;
      if (tagOut !== e.expTag || predPc !== e.expPc) begin
        errors++;
        $display("[TB] FAIL update_low_hold pc=%h got tag=%h pred=%h want tag=%h pred=%h",
                 e.pc, tagOut, predPc, e.expTag, e.expPc);
      end
    end
    // Raising update mid-cycle must not change the current lookup.
    @(negedge clk);
    pcIf    = 32'h0000_0FFC;
    pcEx    = 32'h0000_0FFC;
    aluData = 32'hCCCC_CCCC;
    sbQ.push_back(expOf(32'h0000_0FFC));
    #1;
    update = 1'b1;
    #1;
    e = sbQ.pop_front();
    checks++;
    if (tagOut !== e.expTag || predPc !== e.expPc) begin
      errors++;
      $display("[TB] FAIL update_no_comb got tag=%h pred=%h want tag=%h pred=%h",
               tagOut, predPc, e.expTag, e.expPc);
    end
    @(posedge clk);
    #1;
    update = 1'b0;
    modelTarget[1023] = 32'hCCCC_CCCC;
  endtask

  task automatic test_back_to_back;
    exp_t        e;
    logic [31:0] pcs [8];
    for (int i = 0; i < 8; i++) begin
      pcs[i] = $urandom();
      if (i == 7) pcs[i] = {12'hABC, pcs[2][19:0]};
      applyStimulus(pcs[i], $urandom(), 1'b0);
    end
    for (int i = 0; i < 8; i++) sbQ.push_back(expOf(pcs[i]));
    for (int i = 0; i < 4; i++) sbQ.push_back(expOf($urandom()));
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      @(negedge clk);
      pcIf = e.pc;
      #1;
      checks++;
      if (tagOut !== e.expTag || predPc !== e.expPc) begin
        errors++;
        $display("[TB] FAIL back_to_back pc=%h got tag=%h pred=%h want tag=%h pred=%h",
                 e.pc, tagOut, predPc, e.expTag, e.expPc);
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    update  = 1'b0;
    pcIf    = 32'h0;
    pcEx    = 32'h0;
    aluData = 32'h0;
    test_reset();
    test_write();
    test_alias();
    test_same_cycle();
    test_reset_priority();
    test_index_edges();
    test_update_low();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
